// File: rtl/neuron_layer_ctrl.sv
// neuron_layer_ctrl: sequences one shared combinational neuron across N_OUT outputs with valid/ready result streaming.
// Define NLC_RELU_EN to hard-wire the lower clamp bound to 0 and drop the cfg_xmin register.
module neuron_layer_ctrl #(
  parameter int N_OUT = 8,
  parameter int ADDR_W = 8,
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [31:0]         x_in,
  input  logic signed [11:0]  cfg_xmin,
  input  logic signed [11:0]  cfg_xmax,
  output logic                w_rd_en,
  output logic [ADDR_W-1:0]   w_addr,
  input  logic [47:0]         w_rdata,
  output logic signed [7:0]   n_x1,
  output logic signed [7:0]   n_x2,
  output logic signed [7:0]   n_x3,
  output logic signed [7:0]   n_x4,
  output logic signed [7:0]   n_w1,
  output logic signed [7:0]   n_w2,
  output logic signed [7:0]   n_w3,
  output logic signed [7:0]   n_w4,
  output logic signed [15:0]  n_bias,
  output logic signed [11:0]  n_xmin,
  output logic signed [11:0]  n_xmax,
  input  logic signed [7:0]   n_y,
  output logic                y_valid,
  input  logic                y_ready,
  output logic signed [7:0]   y_data,
  output logic [IW-1:0]       y_idx,
  output logic                busy,
  output logic                done
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, EVAL, OUT, DONE} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0] x_q, w_q;
  logic [15:0] bias_q;
  logic [11:0] xmax_q;
  logic [7:0] y_data_q;
  logic [IW-1:0] y_idx_q;
  logic last, accept;
  assign last = idx_q == IW'(N_OUT - 1);
  assign accept = state_q == IDLE && start && !abort;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        idx_d = '0;
      end
      FETCH: state_d = LOAD;
      LOAD: state_d = EVAL;
      EVAL: state_d = OUT;
      OUT: if (y_ready) begin
        state_d = last ? DONE : FETCH;
        idx_d = last ? idx_q : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      idx_d = idx_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      x_q <= '0;
      xmax_q <= '0;
      w_q <= '0;
      bias_q <= '0;
      y_data_q <= '0;
      y_idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      if (accept) begin
        x_q <= x_in;
        xmax_q <= cfg_xmax;
      end
      if (state_q == LOAD && !abort) {bias_q, w_q} <= w_rdata;
      if (state_q == EVAL && !abort) begin
        y_data_q <= n_y;
        y_idx_q <= idx_q;
      end
    end
  end
`ifdef NLC_RELU_EN
  logic unused_xmin;
  assign unused_xmin = ^cfg_xmin;
  assign n_xmin = '0;
`else
  logic [11:0] xmin_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xmin_q <= '0;
    else if (accept) xmin_q <= cfg_xmin;
  end
  assign n_xmin = xmin_q;
`endif
  assign n_xmax = xmax_q;
  assign {n_x4, n_x3, n_x2, n_x1} = x_q;
  assign {n_w4, n_w3, n_w2, n_w1} = w_q;
  assign n_bias = bias_q;
  assign w_rd_en = state_q == FETCH;
  assign w_addr = ADDR_W'(idx_q);
  assign y_valid = state_q == OUT;
  assign y_data = y_data_q;
  assign y_idx = y_idx_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// tb_neuron_layer_ctrl: table-driven layer runs with a behavioural neuron and weight memory, plus stall/abort/reset sequences.
module tb_neuron_layer_ctrl;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, y_ready = 1;
  logic [31:0] x_in = 0;
  logic signed [11:0] cfg_xmin = 0, cfg_xmax = 0;
  logic w_rd_en, y_valid, busy, done;
  logic [7:0] w_addr;
  logic [47:0] w_rdata = 0;
  logic signed [7:0] n_x1, n_x2, n_x3, n_x4, n_w1, n_w2, n_w3, n_w4, n_y, y_data;
  logic signed [15:0] n_bias;
  logic signed [11:0] n_xmin, n_xmax;
  logic [1:0] y_idx;
  logic signed [31:0] acc;
  logic [47:0] mem [4];
  int total = 0, bad = 0;

  neuron_layer_ctrl #(.N_OUT(4), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_in(x_in),
    .cfg_xmin(cfg_xmin), .cfg_xmax(cfg_xmax), .w_rd_en(w_rd_en), .w_addr(w_addr),
    .w_rdata(w_rdata), .n_x1(n_x1), .n_x2(n_x2), .n_x3(n_x3), .n_x4(n_x4),
    .n_w1(n_w1), .n_w2(n_w2), .n_w3(n_w3), .n_w4(n_w4), .n_bias(n_bias),
    .n_xmin(n_xmin), .n_xmax(n_xmax), .n_y(n_y), .y_valid(y_valid),
    .y_ready(y_ready), .y_data(y_data), .y_idx(y_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (w_rd_en) w_rdata <= mem[w_addr[1:0]];

  always_comb begin
    acc = n_x1 * n_w1 + n_x2 * n_w2 + n_x3 * n_w3 + n_x4 * n_w4 + 32'(n_bias);
    if (acc < 32'(n_xmin)) acc = 32'(n_xmin);
    if (acc > 32'(n_xmax)) acc = 32'(n_xmax);
    n_y = acc[7:0];
  end

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] w;
    logic [15:0] b;
    logic [11:0] xmin;
    logic [11:0] xmax;
    logic [3:0][7:0] y;
  } vec_t;
  vec_t v [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_layer(input vec_t t, input int stall_at, input int abort_at);
    int nout, done_at, stable, after, lat;
    for (int i = 0; i < 4; i++) mem[i] = {t.b + 16'(i), t.w};
    x_in = t.x;
    cfg_xmin = t.xmin;
    cfg_xmax = t.xmax;
    y_ready = 1;
    start = 1;
    tick();
    start = 0;
    x_in = 32'hDEADBEEF;
    cfg_xmin = 12'h5A5;
    cfg_xmax = 12'h0A5;
    nout = 0; done_at = 0; stable = 0; after = 0;
    for (int c = 1; c <= 30; c++) begin
      if (stall_at != 0 && c == stall_at) y_ready = 0;
      if (stall_at != 0 && c == stall_at + 5) y_ready = 1;
      if (abort_at != 0 && c == abort_at) abort = 1;
      if (abort_at != 0 && c == abort_at + 1) begin
        abort = 0;
        chk("abort_idle", {31'd0, busy | y_valid}, 0);
      end
      if (c == 3) begin
`ifdef NLC_RELU_EN
        chk("n_xmin", 32'(n_xmin), 0);
`else
        chk("n_xmin", 32'(n_xmin), 32'(signed'(t.xmin)));
`endif
        chk("n_xmax", 32'(n_xmax), 32'(signed'(t.xmax)));
      end
      if (stall_at != 0 && c >= stall_at && c < stall_at + 5 && y_valid && y_idx == 1 && y_data == t.y[1])
        stable++;
      if (y_valid && y_ready) begin
        lat = 4 + 4 * nout + ((stall_at != 0 && nout >= 1) ? 5 : 0);
        if (nout < 4) begin
          chk("y_data", {24'd0, y_data}, {24'd0, t.y[nout]});
          chk("y_idx", {30'd0, y_idx}, nout);
          chk("y_cycle", c, lat);
        end
        nout++;
      end
      if (done && done_at == 0) done_at = c;
      if (abort_at != 0 && c > abort_at && (w_rd_en || y_valid || done)) after++;
      tick();
    end
    if (abort_at != 0) begin
      chk("abort_nout", nout, 2);
      chk("abort_no_done", done_at, 0);
      chk("abort_quiet", after, 0);
    end else begin
      chk("nout", nout, 4);
      chk("done_at", done_at, stall_at != 0 ? 22 : 17);
      chk("busy_end", {31'd0, busy}, 0);
    end
    if (stall_at != 0) chk("stall_stable", stable, 5);
  endtask

  int act_cnt;

  initial begin
    v[0] = '{x: 32'h04030201, w: 32'h01010101, b: 16'd0, xmin: 12'hF81, xmax: 12'h07F,
             y: {8'd13, 8'd12, 8'd11, 8'd10}};
    v[1] = '{x: 32'h7F7F7F7F, w: 32'h7F7F7F7F, b: 16'd0, xmin: 12'hF81, xmax: 12'h07F,
             y: {8'h7F, 8'h7F, 8'h7F, 8'h7F}};
`ifdef NLC_RELU_EN
    v[2] = '{x: 32'h04030201, w: 32'hFFFFFFFF, b: 16'd6, xmin: 12'hF9C, xmax: 12'h07F,
             y: {8'h00, 8'h00, 8'h00, 8'h00}};
`else
    v[2] = '{x: 32'h04030201, w: 32'hFFFFFFFF, b: 16'd6, xmin: 12'hFFD, xmax: 12'h07F,
             y: {8'hFF, 8'hFE, 8'hFD, 8'hFD}};
`endif
    v[3] = '{x: 32'hFE05F903, w: 32'h02FF0304, b: 16'd20, xmin: 12'hF81, xmax: 12'd3,
             y: {8'd3, 8'd3, 8'd3, 8'd2}};
    for (int i = 0; i < 4; i++) mem[i] = '0;
    tick();
    tick();
    chk("rst_outs", {31'd0, |{w_rd_en, w_addr, n_x1, n_x2, n_x3, n_x4, n_w1, n_w2, n_w3, n_w4,
                               n_bias, n_xmin, n_xmax, y_valid, y_data, y_idx, busy, done}}, 0);
    rst_n = 1;
    act_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy || w_rd_en || y_valid || done) act_cnt++;
    end
    chk("idle_quiet", act_cnt, 0);
    for (int e = 0; e < 4; e++) run_layer(v[e], 0, 0);
    run_layer(v[0], 8, 0);
    run_layer(v[0], 0, 11);
    run_layer(v[3], 0, 0);
    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    chk("start_abort_idle", {31'd0, busy}, 0);
    tick();
    chk("start_abort_idle2", {31'd0, busy | w_rd_en}, 0);
    for (int i = 0; i < 4; i++) mem[i] = {16'd0, v[0].w};
    x_in = v[0].x;
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 6; c++) tick();
    #2 rst_n = 0;
    #1;
    chk("async_rst", {31'd0, |{w_rd_en, n_x1, n_w1, n_bias, n_xmax, y_valid, y_data, y_idx, busy, done}}, 0);
    tick();
    rst_n = 1;
    act_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy || w_rd_en || y_valid || done) act_cnt++;
    end
    chk("post_rst_quiet", act_cnt, 0);
    run_layer(v[1], 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neuron_layer_ctrl.md
# neuron_layer_ctrl

Sequencer that time-multiplexes one combinational `neuron` instance across a fully-connected layer of `N_OUT` output neurons. On `start` it latches one 4-element input vector and the clamp bounds, then fetches each output neuron's four weights and bias from a weight memory. It drives the shared neuron datapath with those values and streams each result out on a valid/ready port. It sits between the layer-level scheduler and the `neuron` datapath plus its weight ROM/RAM.

## Interface
Parameters:
- `N_OUT`, 8: output neurons per layer, ≥1.
- `ADDR_W`, 8: weight-memory address width, 2^ADDR_W ≥ N_OUT.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin layer; sampled only in IDLE.
- `abort`  in  1  cancel layer; synchronous.
- `x_in`  in  32  {X4,X3,X2,X1}, each signed 8-bit; latched on accepted start.
- `cfg_xmin`, `cfg_xmax`  in  12 each  signed clamp bounds; latched on accepted start.
- `w_rd_en`  out  1  weight-memory read strobe.
- `w_addr`  out  ADDR_W  weight word index (= neuron index).
- `w_rdata`  in  48  {bias[15:0], W4, W3, W2, W1}; valid the cycle after `w_rd_en`.
- `n_x1`..`n_x4`, `n_w1`..`n_w4`  out  8 each, signed  neuron operands.
- `n_bias`  out  16 signed.
- `n_xmin`, `n_xmax`  out  12 signed.
- `n_y`  in  8 signed  neuron result, combinational from the operands.
- `y_valid`  out  1; `y_ready`  in  1; `y_data`  out  8 signed; `y_idx`  out  $clog2(N_OUT) (min 1 bit).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at layer completion.

## Operation
- FSM states: IDLE, FETCH, LOAD, EVAL, OUT, DONE.
- IDLE: `start`=1 latches `x_in`/cfg bounds, clears index to 0 → FETCH.
- FETCH: `w_rd_en`=1, `w_addr`=index → LOAD.
- LOAD: register `w_rdata` into weight/bias registers → EVAL.
- EVAL: all neuron operands come from registers and are stable; capture `n_y` into `y_data`, index into `y_idx` → OUT.
- OUT: `y_valid`=1; `y_data` and `y_idx` are held until the cycle `y_valid`&&`y_ready`. On that handshake: if index==N_OUT-1 → DONE, else index+1 → FETCH.
- DONE: `done`=1 for one cycle → IDLE.
- `abort`=1 in any non-IDLE state → IDLE next edge. No `done`; `y_valid` drops. Abort has priority over handshake/transition.
- `start` outside IDLE is ignored. `start` and `abort` both high in IDLE: abort wins, stay IDLE.
- The index counter saturates logic at N_OUT-1 and never wraps past it. N_OUT=1 yields exactly one output, then DONE.
- Operand registers keep their values in IDLE/DONE. The neuron port never sees X/partial data during EVAL.

## Timing
- Reset values: all outputs 0, FSM=IDLE, index=0, operand registers 0.
- Start accepted at edge T0: FETCH in cycle T0+1; LOAD T0+2; EVAL T0+3; first `y_valid` in cycle T0+4.
- Per neuron, with `y_ready` tied high: 4 cycles. Full layer: 4·N_OUT+1 cycles from start edge to `done` pulse inclusive.
- Backpressure adds one cycle per cycle `y_ready` is low in OUT. Outputs are fully stable while stalled.
- `busy` rises the cycle after the accepted start and falls the cycle after DONE.
- `rst_n` low mid-layer: immediate asynchronous return to reset values. No `done`, no partial outputs afterwards.

## Configuration
- `NLC_RELU_EN` defined: `n_xmin` is hard-wired to 0 (ReLU-style lower clamp). `cfg_xmin` is ignored and its register is not synthesized. `n_xmax` still comes from `cfg_xmax`.
- Undefined: `n_xmin` comes from latched `cfg_xmin`.

## Test plan
- Reset then idle: `rst_n` low, then high for 10 cycles with `start`=0 → all outputs 0, `busy`=0, `w_rd_en` never high.
- N_OUT=4, x_in={4,3,2,1}, memory word k = weights {1,1,1,1}, bias=k, `y_ready`=1, bounds ±127 → `y_data` 10,11,12,13 with `y_idx` 0..3. First `y_valid` 4 cycles after start; `done` at cycle 17.
- Saturation: weights {127,127,127,127}, x={127,127,127,127}, xmin=-127, xmax=127 → `y_data` equals the neuron model's clamp result for 127. `n_xmin`/`n_xmax` read -127/127.
- Backpressure: hold `y_ready`=0 for 5 cycles on neuron 1 → `y_valid`, `y_data`, `y_idx` stable throughout. Layer completes 5 cycles later than baseline.
- Abort in EVAL of neuron 2 → IDLE next cycle, no `done`, no further `w_rd_en`. A new start then restarts at index 0.
- `NLC_RELU_EN` build: cfg_xmin=-100, pre-clamp negative result → `y_data`=0 and `n_xmin`=0.
